// File: rtl/pair_stream_generator.sv
// Walks every (neighbour, home) pair of a cell-pair job, issuing cache reads and
// producing pair-valid / nb-load / release strobes aligned with the read data.
module pair_stream_generator #(
  parameter int HOME_ADDR_WIDTH = 8,
  parameter int NB_ADDR_WIDTH   = 8,
  parameter int RD_LATENCY      = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic [HOME_ADDR_WIDTH-1:0] i_num_home,
  input  logic [NB_ADDR_WIDTH-1:0]   i_num_nb,
  input  logic                       i_stall,
  output logic                       o_home_rd_en,
  output logic [HOME_ADDR_WIDTH-1:0] o_home_rd_addr,
  output logic                       o_nb_rd_en,
  output logic [NB_ADDR_WIDTH-1:0]   o_nb_rd_addr,
  output logic                       o_pair_valid,
  output logic                       o_nb_load,
  output logic                       o_nb_reg_release_flag,
  output logic                       o_busy,
  output logic                       o_done
);
  localparam int DW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(RD_LATENCY - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                 state;
  logic [HOME_ADDR_WIDTH-1:0] home_cnt, home_last;
  logic [NB_ADDR_WIDTH-1:0]   nb_cnt, nb_last;
  logic [DW-1:0]              drain_cnt;
  // Stage 0 is the registered issue itself; stage RD_LATENCY lines up with read data.
  logic [RD_LATENCY:0]        vld_pipe, first_pipe, last_pipe;
  logic                       issue, home_wrap, nb_wrap;

  assign issue     = (state == S_RUN) && !i_stall;
  assign home_wrap = (home_cnt == home_last);
  assign nb_wrap   = (nb_cnt == nb_last);

  assign o_home_rd_en          = vld_pipe[0];
  assign o_nb_rd_en            = first_pipe[0];
  assign o_pair_valid          = vld_pipe[RD_LATENCY];
  assign o_nb_load             = vld_pipe[RD_LATENCY] & first_pipe[RD_LATENCY];
  assign o_nb_reg_release_flag = vld_pipe[RD_LATENCY] & last_pipe[RD_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      home_cnt       <= '0;
      nb_cnt         <= '0;
      home_last      <= '0;
      nb_last        <= '0;
      drain_cnt      <= '0;
      vld_pipe       <= '0;
      first_pipe     <= '0;
      last_pipe      <= '0;
      o_home_rd_addr <= '0;
      o_nb_rd_addr   <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
    end else begin
      // The pipeline never freezes; the filter threshold leaves room for in-flight pairs.
      vld_pipe   <= {vld_pipe[RD_LATENCY-1:0], issue};
      first_pipe <= {first_pipe[RD_LATENCY-1:0], issue && (home_cnt == '0)};
      last_pipe  <= {last_pipe[RD_LATENCY-1:0], issue && home_wrap};
      o_done     <= 1'b0;
      if (issue) begin
        o_home_rd_addr <= home_cnt;
        o_nb_rd_addr   <= nb_cnt;
      end
      case (state)
        S_IDLE: begin
          o_busy <= i_start;
          if (i_start) begin
            // Compare against count-1 so a full-range count never overflows the counter.
            home_last <= i_num_home - 1'b1;
            nb_last   <= i_num_nb - 1'b1;
            home_cnt  <= '0;
            nb_cnt    <= '0;
            state     <= (i_num_home == '0 || i_num_nb == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (issue) begin
            if (home_wrap) begin
              home_cnt <= '0;
              nb_cnt   <= nb_cnt + 1'b1;
              if (nb_wrap) begin
                state     <= S_DRAIN;
                drain_cnt <= '0;
              end
            end else begin
              home_cnt <= home_cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == DRAIN_LAST) state <= S_DONE;
        end
        S_DONE: begin
          o_done <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pair_stream_generator.sv
// Bench for pair_stream_generator: table of jobs, random jobs with random stalls,
// and a mid-job reset sequence, all checked cycle by cycle against a pair-index model.
module tb_pair_stream_generator;
  localparam int L = 2;

  logic       clk = 1'b0;
  logic       rst, i_start, i_stall;
  logic [7:0] i_num_home, i_num_nb;
  logic       o_home_rd_en, o_nb_rd_en, o_pair_valid, o_nb_load;
  logic       o_nb_reg_release_flag, o_busy, o_done;
  logic [7:0] o_home_rd_addr, o_nb_rd_addr;

  always #5 clk = ~clk;

  pair_stream_generator #(.HOME_ADDR_WIDTH(8), .NB_ADDR_WIDTH(8), .RD_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_num_home(i_num_home), .i_num_nb(i_num_nb),
    .i_stall(i_stall), .o_home_rd_en(o_home_rd_en), .o_home_rd_addr(o_home_rd_addr),
    .o_nb_rd_en(o_nb_rd_en), .o_nb_rd_addr(o_nb_rd_addr), .o_pair_valid(o_pair_valid),
    .o_nb_load(o_nb_load), .o_nb_reg_release_flag(o_nb_reg_release_flag),
    .o_busy(o_busy), .o_done(o_done)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit stall_hist [0:4095];

  typedef struct {
    int nh; int nn; int st_lo; int st_hi; int xstart; int exp_pairs; int exp_done;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Cycle 0 presents i_start; pair k is (home k%nh, nb k/nh); a RUN cycle c-1 without
  // stall yields an issue in cycle c, data L cycles later, done L+1 after the last issue.
  task automatic run_job(input int nh, input int nn, input int st_lo, input int st_hi,
                         input int xstart, input bit rnd, output int pairs, output int done_c);
    int  total, issued, vk, last_issue;
    int  vq [$];
    bit  exp_rd, exp_vld, exp_done, done_past, st_prev, st;
    total = nh * nn; issued = 0; vk = 0; last_issue = -1;
    done_past = 0; pairs = 0; done_c = -1;
    i_num_home = nh[7:0];
    i_num_nb   = nn[7:0];
    for (int c = 0; c < 4000 && !done_past; c++) begin
      @(negedge clk);
      st_prev = (c > 0) ? stall_hist[c-1] : 1'b0;
      exp_rd  = (c >= 2) && (issued < total) && !st_prev;
      chk("home_rd_en", o_home_rd_en, exp_rd);
      if (exp_rd) begin
        chk("home_addr", o_home_rd_addr, issued % nh);
        chk("nb_rd_en", o_nb_rd_en, (issued % nh) == 0);
        if ((issued % nh) == 0) chk("nb_addr", o_nb_rd_addr, issued / nh);
        vq.push_back(c);
        issued++;
        if (issued == total) last_issue = c;
      end else begin
        chk("nb_rd_en_idle", o_nb_rd_en, 0);
      end
      exp_vld = (vq.size() > 0) && (vq[0] == c - L);
      chk("pair_valid", o_pair_valid, exp_vld);
      if (exp_vld) begin
        void'(vq.pop_front());
        chk("nb_load", o_nb_load, (vk % nh) == 0);
        chk("release", o_nb_reg_release_flag, (vk % nh) == nh - 1);
        vk++;
      end else begin
        chk("nb_load_idle", o_nb_load, 0);
        chk("release_idle", o_nb_reg_release_flag, 0);
      end
      if (o_pair_valid === 1'b1) pairs++;
      exp_done = (total == 0) ? (c == 2) : (last_issue >= 0 && c == last_issue + L + 1);
      chk("done", o_done, exp_done);
      chk("busy", o_busy, (c >= 1) && !done_past);
      if (o_done === 1'b1 && done_c < 0) done_c = c;
      st = rnd ? ($urandom_range(0, 2) == 0) : (c >= st_lo && c <= st_hi);
      stall_hist[c] = st;
      i_stall = st;
      i_start = (c == 0) || (xstart > 0 && c == xstart);
      if (exp_done) begin
        done_past = 1'b1;
        i_start = 1'b0;
      end
    end
    if (!done_past) chk("job_timeout", 0, 1);
    i_start = 1'b0;
    i_stall = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pairs, done_c, cnt, acc, nh, nn;
    // nh, nn, stall window, extra start cycle, expected pairs, expected done cycle
    vecs[0] = '{3,   2,  -1, -2, 0,   6,  10};
    vecs[1] = '{3,   2,   3,  5, 0,   6,  13};
    vecs[2] = '{0,   5,  -1, -2, 0,   0,   2};
    vecs[3] = '{3,   2,  -1, -2, 4,   6,  10};
    vecs[4] = '{1,   4,  -1, -2, 0,   4,   8};
    vecs[5] = '{5,   0,  -1, -2, 0,   0,   2};
    vecs[6] = '{255, 1,  -1, -2, 0, 255, 259};
    vecs[7] = '{1, 255,  -1, -2, 0, 255, 259};

    rst = 1'b1; i_start = 1'b0; i_stall = 1'b0; i_num_home = '0; i_num_nb = '0;
    repeat (3) @(negedge clk);
    chk("rst_home_rd_en", o_home_rd_en, 0);
    chk("rst_nb_rd_en", o_nb_rd_en, 0);
    chk("rst_pair_valid", o_pair_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_home_addr", o_home_rd_addr, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_job(vecs[i].nh, vecs[i].nn, vecs[i].st_lo, vecs[i].st_hi, vecs[i].xstart, 1'b0,
              pairs, done_c);
      chk("vec_pairs", pairs, vecs[i].exp_pairs);
      chk("vec_done_cycle", done_c, vecs[i].exp_done);
    end

    // Abort a 3x2 job after its fourth issue.
    i_num_home = 8'd3; i_num_nb = 8'd2;
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20 && cnt < 4; k++) begin
      @(negedge clk);
      if (o_home_rd_en === 1'b1) cnt++;
    end
    chk("abort_issues", cnt, 4);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rd_en", o_home_rd_en, 0);
    chk("abort_nb_rd_en", o_nb_rd_en, 0);
    chk("abort_valid", o_pair_valid, 0);
    chk("abort_load", o_nb_load, 0);
    chk("abort_release", o_nb_reg_release_flag, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_done", o_done, 0);
    chk("abort_addr", o_home_rd_addr, 0);
    rst = 1'b0;
    acc = 0;
    repeat (6) begin
      @(negedge clk);
      acc += int'(o_pair_valid) + int'(o_done) + int'(o_home_rd_en) + int'(o_busy);
    end
    chk("abort_quiet", acc, 0);
    run_job(3, 2, -1, -2, 0, 1'b0, pairs, done_c);
    chk("post_abort_pairs", pairs, 6);
    chk("post_abort_done", done_c, 10);

    for (int j = 0; j < 20; j++) begin
      nh = $urandom_range(0, 6);
      nn = $urandom_range(0, 6);
      run_job(nh, nn, 0, 0, 0, 1'b1, pairs, done_c);
      chk("rand_pairs", pairs, nh * nn);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pair_stream_generator.md
Name: pair_stream_generator

Overview:
- Upstream of the filter dispatcher delay stage. Walks every (neighbour particle, home particle) pair of one cell-pair job.
- For each pair, issues reads to the home offset cache and the neighbour position cache.
- Produces a pair-valid strobe and a neighbour-register release flag, both aligned with the cache read data, which feed the dispatcher's pair/nb inputs.
- Honours back-pressure from the filter bank.

Parameters:
- HOME_ADDR_WIDTH, 8, width of home particle index/count.
- NB_ADDR_WIDTH, 8, width of neighbour particle index/count.
- RD_LATENCY, 2, cache read latency in cycles (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- i_start  in  1  job start pulse; sampled only in IDLE
- i_num_home  in  HOME_ADDR_WIDTH  home particle count, latched at start
- i_num_nb  in  NB_ADDR_WIDTH  neighbour particle count, latched at start
- i_stall  in  1  filter bank almost-full; blocks new issues
- o_home_rd_en  out  1  home cache read enable
- o_home_rd_addr  out  HOME_ADDR_WIDTH  home cache address
- o_nb_rd_en  out  1  neighbour cache read enable
- o_nb_rd_addr  out  NB_ADDR_WIDTH  neighbour cache address
- o_pair_valid  out  1  read data valid for one pair (RD_LATENCY after issue)
- o_nb_load  out  1  neighbour data on cache output is new; downstream loads nb register
- o_nb_reg_release_flag  out  1  aligned pair is the last home particle for the current neighbour
- o_busy  out  1  high from accepted start until DONE exits
- o_done  out  1  single-cycle job completion pulse

Behaviour:
- Reset: rst synchronous, active-high; clock clk.
  - All outputs 0, counters 0, delay pipeline cleared, FSM to IDLE.
  - Reset mid-job aborts the job immediately; no done pulse is produced.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On i_start, latch the counts, clear home_cnt/nb_cnt, set o_busy.
  - If either count is 0, go to DONE with no reads issued. Otherwise go to RUN.
  - i_start outside IDLE is ignored.
- RUN, issue cycle (i_stall==0):
  - o_home_rd_en=1, o_home_rd_addr=home_cnt.
  - o_nb_rd_en=1 only when home_cnt==0; o_nb_rd_addr=nb_cnt.
  - Last-home tag = (home_cnt==num_home-1).
  - home_cnt increments. At num_home-1 it wraps to 0 and nb_cnt increments.
  - After issuing the final pair (home_cnt==num_home-1 and nb_cnt==num_nb-1), go to DRAIN.
- RUN, stall cycle (i_stall==1): no read enables; counters hold; state holds.
  - Rd enables and addresses are registered outputs reflecting the current-cycle decision on i_stall.
- Alignment pipeline:
  - A shift register of depth RD_LATENCY carries {valid, nb_first, last_home}.
  - Inputs to the pipeline: valid = issue, nb_first = issue & home_cnt==0, last_home = last-home tag.
  - Its outputs drive o_pair_valid, o_nb_load, o_nb_reg_release_flag. All three are 0 whenever valid is 0.
  - The pipeline always advances; i_stall does not freeze it. The filter almost-full threshold carries ≥RD_LATENCY+1 slack.
- DRAIN: a counter waits RD_LATENCY cycles until the pipeline empties, then go to DONE.
- DONE: o_done=1 for one cycle, o_busy=0 on the next cycle; return to IDLE.
  - A new i_start is accepted the cycle after DONE.
- Total issued pairs = num_home*num_nb.
  - o_nb_load count = num_nb.
  - o_nb_reg_release_flag count = num_nb.
- num_home==1: every pair has o_nb_load and o_nb_reg_release_flag both high.
- Counts equal to the maximum representable values (2^W-1) are supported; the wrap compare uses the latched count minus 1, so there is no counter overflow.
- Throughput: one pair per cycle when unstalled.

Test Plan:
- num_home=3, num_nb=2, RD_LATENCY=2, no stall -> home addrs 0,1,2,0,1,2; nb_rd_en on cycles 1 and 4 with addr 0,1; o_pair_valid 6 cycles starting 2 after first issue; release flag on pairs 3 and 6; o_done one cycle, RD_LATENCY+1 after last issue.
- Same job, i_stall high for 3 cycles after the second issue -> no rd_en during the stall; address sequence unchanged; 6 valids total; in-flight pairs still emerge during the stall.
- i_num_home=0, num_nb=5, start -> no rd_en ever; o_done pulses; o_busy high exactly 2 cycles.
- Second i_start during RUN -> ignored; pair count stays 6; a start the cycle after o_done launches a new job.
- rst asserted after 4 issues of a 3x2 job -> all outputs 0 next cycle; no o_done; no valids from aborted reads emerge; a fresh start runs normally.
- num_home=1, num_nb=4 -> 4 pairs, each with o_nb_load=1 and o_nb_reg_release_flag=1; nb addrs 0..3.
